// File: rtl/ysyx_25030093_pkg.sv
// ysyx_25030093_pkg: shared FSM state encoding and default sequencer constants
package ysyx_25030093_pkg;
  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT, S_ERR
  } state_t;
  localparam logic [31:0] DEF_RESET_PC = 32'h8000_0000;
  localparam int DEF_TIMEOUT = 255;
endpackage

// File: rtl/ysyx_25030093_wait_timer.sv
// ysyx_25030093_wait_timer: clearable 8-bit wait counter, expire marks the last allowed wait cycle
module ysyx_25030093_wait_timer #(
  parameter int LIMIT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic inc,
  output logic expire
);
  logic [7:0] cnt;
  always_ff @(posedge clk or posedge rst)
    if (rst) cnt <= '0;
    else cnt <= clr ? '0 : cnt + {7'd0, inc};
  assign expire = cnt == 8'(LIMIT - 1);
endmodule

// File: rtl/ysyx_25030093_mc_ctrl.sv
// ysyx_25030093_mc_ctrl: multi-cycle fetch/decode/exec/mem/wb sequencer owning pc and perf counters
module ysyx_25030093_mc_ctrl
  import ysyx_25030093_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEF_RESET_PC,
  parameter int          TIMEOUT  = DEF_TIMEOUT
) (
  input  logic        clk,
  input  logic        rst,
  output logic        ifu_req,
  output logic [31:0] ifu_addr,
  input  logic        ifu_rsp_valid,
  input  logic [31:0] ifu_rsp_data,
  output logic [31:0] inst,
  input  logic        dec_wen,
  input  logic        dec_load,
  input  logic        dec_store,
  input  logic        dec_ebreak,
  input  logic        dec_illegal,
  input  logic [31:0] next_pc,
  output logic        lsu_req,
  output logic        lsu_we,
  input  logic        lsu_rsp_valid,
  output logic        rf_wen,
  output logic [31:0] pc,
  output logic        halted,
  output logic        error,
  output logic [63:0] cycle_cnt,
  output logic [63:0] instret
);
  state_t state, state_n;
  logic waiting, rsp, expire, retire;
  assign waiting = state == S_FETCH || state == S_MEM;
  assign rsp = state == S_FETCH ? ifu_rsp_valid : lsu_rsp_valid;
  ysyx_25030093_wait_timer #(.LIMIT(TIMEOUT)) u_timer (
    .clk(clk), .rst(rst), .clr(!waiting), .inc(waiting && !rsp), .expire(expire)
  );
  always_comb begin
    state_n = state;
    case (state)
      S_IDLE:   state_n = S_FETCH;
      S_FETCH:  state_n = ifu_rsp_valid ? S_DECODE : expire ? S_ERR : S_FETCH;
      S_DECODE: state_n = dec_illegal ? S_ERR : dec_ebreak ? S_HALT : S_EXEC;
      S_EXEC:   state_n = dec_load || dec_store ? S_MEM : S_WB;
      S_MEM:    state_n = lsu_rsp_valid ? S_WB : expire ? S_ERR : S_MEM;
      S_WB:     state_n = S_FETCH;
      default:  state_n = state;
    endcase
    ifu_req = state == S_FETCH;
    lsu_req = state == S_MEM;
    lsu_we  = state == S_MEM && dec_store;
    rf_wen  = state == S_WB && dec_wen && !dec_store;
    halted  = state == S_HALT;
    error   = state == S_ERR;
    retire  = state == S_WB || (state == S_DECODE && !dec_illegal && dec_ebreak);
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state     <= S_IDLE;
      pc        <= RESET_PC;
      inst      <= '0;
      cycle_cnt <= '0;
      instret   <= '0;
    end else begin
      state <= state_n;
      if (state == S_FETCH && ifu_rsp_valid) inst <= ifu_rsp_data;
      if (state == S_WB) pc <= next_pc;
      if (!halted && !error) cycle_cnt <= cycle_cnt + 64'd1;
      if (retire) instret <= instret + 64'd1;
    end
  assign ifu_addr = pc;
endmodule

// File: tb/tb_ysyx_25030093_mc_ctrl.sv
// tb_ysyx_25030093_mc_ctrl: per-instruction trace model with randomized waits and bus noise
module tb_ysyx_25030093_mc_ctrl;
  localparam logic [31:0] RPC = 32'h8000_0000;
  localparam int TO = 255;

  logic clk = 1'b0;
  logic rst;
  logic ifu_req, ifu_rsp_valid, dec_wen, dec_load, dec_store, dec_ebreak, dec_illegal;
  logic lsu_req, lsu_we, lsu_rsp_valid, rf_wen, halted, error;
  logic [31:0] ifu_addr, ifu_rsp_data, inst, next_pc, pc;
  logic [63:0] cycle_cnt, instret;

  ysyx_25030093_mc_ctrl dut (
    .clk(clk), .rst(rst), .ifu_req(ifu_req), .ifu_addr(ifu_addr),
    .ifu_rsp_valid(ifu_rsp_valid), .ifu_rsp_data(ifu_rsp_data), .inst(inst),
    .dec_wen(dec_wen), .dec_load(dec_load), .dec_store(dec_store),
    .dec_ebreak(dec_ebreak), .dec_illegal(dec_illegal), .next_pc(next_pc),
    .lsu_req(lsu_req), .lsu_we(lsu_we), .lsu_rsp_valid(lsu_rsp_valid),
    .rf_wen(rf_wen), .pc(pc), .halted(halted), .error(error),
    .cycle_cnt(cycle_cnt), .instret(instret)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit ireq, lreq, we, rf, h, e;
    logic [31:0] pc, inst;
    logic [63:0] cc, ir;
  } exp_t;

  exp_t exp_q[$];
  exp_t ex;
  int n_cmp = 0, n_bad = 0;
  logic [31:0] m_pc, m_inst;
  logic [63:0] m_cyc, m_ret;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] want);
    n_cmp++;
    if (act !== want) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, want, $time);
    end
  endtask

  always @(negedge clk)
    if (exp_q.size() > 0) begin
      ex = exp_q.pop_front();
      chk("ifu_req", 64'(ifu_req), 64'(ex.ireq));
      chk("lsu_req", 64'(lsu_req), 64'(ex.lreq));
      chk("lsu_we", 64'(lsu_we), 64'(ex.we));
      chk("rf_wen", 64'(rf_wen), 64'(ex.rf));
      chk("halted", 64'(halted), 64'(ex.h));
      chk("error", 64'(error), 64'(ex.e));
      chk("pc", 64'(pc), 64'(ex.pc));
      chk("ifu_addr", 64'(ifu_addr), 64'(ex.pc));
      chk("inst", 64'(inst), 64'(ex.inst));
      chk("cycle_cnt", cycle_cnt, ex.cc);
      chk("instret", instret, ex.ir);
    end

  task automatic cyc(input bit ireq, input bit lreq, input bit we, input bit rf, input bit h, input bit e);
    exp_q.push_back('{ireq, lreq, we, rf, h, e, m_pc, m_inst, m_cyc, m_ret});
    @(posedge clk); #1;
    if (!h && !e) m_cyc++;
  endtask

  task automatic bus_noise();
    ifu_rsp_valid = 1'($urandom);
    ifu_rsp_data  = $urandom;
    lsu_rsp_valid = 1'($urandom);
  endtask

  task automatic dec_noise();
    {dec_wen, dec_load, dec_store, dec_ebreak, dec_illegal} = 5'($urandom);
    next_pc = $urandom;
  endtask

  task automatic tail(input bit h, input bit e);
    repeat (4) begin
      bus_noise(); dec_noise();
      ifu_rsp_valid = 1'b1;
      cyc(0, 0, 0, 0, h, e);
    end
  endtask

  task automatic chk_reset();
    chk("rst_pc", 64'(pc), 64'(RPC));
    chk("rst_ifu_addr", 64'(ifu_addr), 64'(RPC));
    chk("rst_reqs", {60'd0, ifu_req, lsu_req, lsu_we, rf_wen}, 64'd0);
    chk("rst_status", {62'd0, halted, error}, 64'd0);
    chk("rst_inst", 64'(inst), 64'd0);
    chk("rst_cycle_cnt", cycle_cnt, 64'd0);
    chk("rst_instret", instret, 64'd0);
  endtask

  task automatic do_reset(input bit now);
    dec_wen = 1'b1; dec_store = 1'b1;
    rst = 1'b1;
    #1;
    if (now) chk_reset();
    @(posedge clk); #1;
    chk_reset();
    rst = 1'b0;
    m_pc = RPC; m_inst = '0; m_cyc = '0; m_ret = '0;
    ifu_rsp_valid = 1'b1; lsu_rsp_valid = 1'b1;
    cyc(0, 0, 0, 0, 0, 0);
  endtask

  // kind: 0 alu/branch, 1 load, 2 store, 3 ebreak, 4 illegal (with ebreak also raised)
  task automatic instr(input int kind, input int fw, input int mw, input logic [31:0] data,
                       input logic [31:0] nxt, input bit wen, input int abort);
    bit ld, st, eb, il;
    ld = kind == 1; st = kind == 2; eb = kind >= 3; il = kind == 4;
    for (int i = 0; i <= fw && i < TO; i++) begin
      bus_noise(); dec_noise();
      ifu_rsp_valid = i == fw;
      if (i == fw) ifu_rsp_data = data;
      cyc(1, 0, 0, 0, 0, 0);
    end
    if (fw >= TO) begin tail(0, 1); return; end
    m_inst = data;
    {dec_wen, dec_load, dec_store, dec_ebreak, dec_illegal} = {wen, ld, st, eb, il};
    next_pc = nxt;
    bus_noise();
    cyc(0, 0, 0, 0, 0, 0);
    if (il) begin tail(0, 1); return; end
    if (eb) begin m_ret++; tail(1, 0); return; end
    bus_noise();
    cyc(0, 0, 0, 0, 0, 0);
    if (ld || st) begin
      for (int i = 0; i <= mw && i < TO; i++) begin
        bus_noise();
        lsu_rsp_valid = i == mw;
        cyc(0, 1, st, 0, 0, 0);
        if (i == abort) return;
      end
      if (mw >= TO) begin tail(0, 1); return; end
    end
    bus_noise();
    cyc(0, 0, 0, wen && !st, 0, 0);
    m_pc = nxt;
    m_ret++;
  endtask

  initial begin
    ifu_rsp_valid = 0; ifu_rsp_data = 0; lsu_rsp_valid = 0; next_pc = 0;
    {dec_wen, dec_load, dec_store, dec_ebreak, dec_illegal} = '0;
    do_reset(0);
    instr(0, 0, 0, 32'h0010_0093, 32'h8000_0004, 1, -1);
    chk("addi_pc", 64'(pc), 64'h8000_0004);
    chk("addi_instret", instret, 64'd1);
    chk("addi_cycles", cycle_cnt, 64'd5);
    instr(1, 0, 3, 32'h0000_a103, 32'h8000_0008, 1, -1);
    chk("lw_cycles", cycle_cnt, 64'd13);
    chk("lw_instret", instret, 64'd2);
    instr(2, 1, 0, 32'h0020_a023, 32'h8000_000c, 0, -1);
    chk("sw_cycles", cycle_cnt, 64'd19);
    chk("sw_instret", instret, 64'd3);
    for (int n = 0; n < 40; n++)
      instr($urandom_range(0, 2), $urandom_range(0, 3), $urandom_range(0, 3), $urandom,
            $urandom & 32'hffff_fffc, 1'($urandom), -1);
    instr(3, $urandom_range(0, 2), 0, 32'h0010_0073, 32'h0, 0, -1);
    chk("ebreak_halted", 64'(halted), 64'd1);
    chk("ebreak_ifu_req", 64'(ifu_req), 64'd0);
    do_reset(0);
    instr(0, 254, 0, 32'h0000_0013, 32'h8000_0010, 1, -1);
    chk("late_rsp_error", 64'(error), 64'd0);
    chk("late_rsp_pc", 64'(pc), 64'h8000_0010);
    instr(0, 255, 0, 32'h0000_0013, 32'h8000_0014, 1, -1);
    chk("fetch_to_error", 64'(error), 64'd1);
    chk("fetch_to_cycles", cycle_cnt, 64'd514);
    do_reset(0);
    instr(4, 0, 0, 32'hffff_ffff, 32'h0, 1, -1);
    chk("illegal_error", 64'(error), 64'd1);
    chk("illegal_halted", 64'(halted), 64'd0);
    chk("illegal_instret", instret, 64'd0);
    do_reset(0);
    instr(1, 0, 255, 32'h0000_2083, 32'h0, 1, -1);
    chk("mem_to_cycles", cycle_cnt, 64'd259);
    do_reset(0);
    instr(0, 0, 0, 32'h0010_0093, 32'h8000_0004, 1, -1);
    instr(1, 1, 5, 32'h0000_a103, 32'h8000_0040, 1, 2);
    do_reset(1);
    instr(0, 0, 0, 32'h0010_0093, 32'h8000_0004, 1, -1);
    chk("post_rst_instret", instret, 64'd1);
    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
